add_mul_seq: RTL and testbench
==============================

// Module: add_mul_seq
// PURPOSE
//   Sequencer that reuses the shared N-bit ripple adder (module add) to perform
//   unsigned N x N -> 2N multiply by iterative shift-and-add. One adder
//   operation per cycle, fixed latency of N cycles. Sits in EX as the
//   multi-cycle unit for RV32M MUL/MULHU and stalls the pipeline via busy.
// PARAMETERS
//   N      32   operand width; product is 2N bits; N >= 2
// PORTS
//   clk       in   1    single clock, rising edge
//   rst_n     in   1    asynchronous, active-low reset
//   start     in   1    request; accepted only when busy=0
//   flush     in   1    synchronous abort of an in-flight operation
//   op_a      in   N    multiplicand, sampled at the accepting edge
//   op_b      in   N    multiplier, sampled at the accepting edge
//   busy      out  1    operation in flight; pipeline must hold EX
//   done      out  1    single-cycle pulse: product valid
//   product   out  2N   unsigned result {hi,lo}; held until the next accept
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, busy=0, done=0, product=0, count=0.
//   FSM: IDLE -> RUN on (start & ~flush); RUN -> IDLE after N iterations or
//     on flush. There is no DONE state: done is registered on the exit edge.
//   Accept at edge k: mcand<=op_a, acc<=0, mq<=op_b, count<=N-1, busy<=1.
//   Each RUN edge: sum[N:0] = {1'b0,acc} + (mq[0] ? {1'b0,mcand} : 0), via an
//     add #(.N(N+1)) instance with zero-extended inputs (the adder has no
//     carry-out, so the width is N+1).
//     {acc,mq} <= {sum[N:0], mq[N-1:1]}  (2N+1 bits, LSB dropped: shift right).
//     count decrements; at count==0 the edge is the last iteration.
//   Last iteration (edge k+N): state<=IDLE, busy<=0, done<=1,
//     product<={acc_next,mq_next}. done clears on the following edge.
//   Latency: start high at edge k -> done high in the cycle after edge k+N.
//   start while busy=1: ignored; operands are not resampled.
//   start in the done cycle: accepted (busy=0). done still deasserts next edge.
//   flush in RUN: state<=IDLE, busy<=0 on that edge. done is not pulsed;
//     product keeps its previous value.
//   flush in IDLE: no effect. flush & start together: flush wins, no accept.
//   op_b==0 or op_a==0: full N-cycle latency; there is no early-out.
//   Async reset mid-operation: immediate return to reset values; no done pulse.
//   count width is $clog2(N). product is never updated except on the last edge.
// STRUCTURE
//   Shared package/header (riscv_defs.vh): XLEN=32 and the M-extension
//     funct3 encodings used by the decoder. The FSM state encoding
//     (IDLE=1'b0, RUN=1'b1) stays local.
//   Sub-module: one instance of add #(.N(N+1)) as the only arithmetic element.
//     No behavioural '+' on the datapath. The count decrement may use '-'.
// TESTING
//   1. 3 x 5: start at edge 0 -> busy=1 edges 1..32, done=1 after edge 32,
//      product=64'h0000_0000_0000_000F.
//   2. 32'hFFFFFFFF x 32'hFFFFFFFF -> product=64'hFFFFFFFE_00000001 after 32
//      cycles (checks the adder carry in bit N).
//   3. 32'h0 x 32'h1234 -> product=0, done still exactly 32 cycles after start.
//   4. Re-assert start with new operands at edge 5 of an op -> ignored; the
//      result is for the original operands. A second start in the done cycle
//      is accepted; its result appears 32 cycles later.
//   5. flush at edge 10 (and again with start=1 in the same cycle) -> busy=0
//      next cycle, no done pulse, product equals the prior result.
//   6. rst_n low mid-op (edge 17) -> busy=0, done=0, product=0 immediately.
//      Random 1000-op compare against a*b with N=32 and N=8.

Source files
------------

// File: rtl/add_mul_seq_pkg.sv
// Shared definitions for the EX-stage multiply sequencer.
package add_mul_seq_pkg;

    localparam int unsigned XLEN = 32;

    // RV32M funct3 encodings used by the decoder
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/add_mul_seq_add.sv
// N-bit ripple-carry adder without carry-out; the shared arithmetic element.
module add #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);

    // Ripple the carry from LSB to MSB; the final carry is discarded
    always_comb begin
        logic carry;
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < int'(N); i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/add_mul_seq.sv
// Iterative shift-and-add unsigned multiplier, one adder pass per cycle.
module add_mul_seq
    import add_mul_seq_pkg::*;
#(
    parameter int unsigned N = XLEN
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           flush,
    input  logic [N-1:0]   op_a,
    input  logic [N-1:0]   op_b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [N-1:0]     mq_q, mq_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2*N-1:0]   product_q, product_d;

    logic [N:0]       add_a, add_b, sum;

    // Partial-product accumulate: acc plus multiplicand when the multiplier LSB is set
    assign add_a = {1'b0, acc_q};
    assign add_b = mq_q[0] ? {1'b0, mcand_q} : '0;

    add #(.N(N + 1)) u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (sum)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    // Next-state, iteration step and result capture
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d = RUN;
                    mcand_d = op_a;
                    acc_d   = '0;
                    mq_d    = op_b;
                    count_d = CW'(N - 1);
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    // {acc,mq} takes {sum, mq>>1}: the LSB of the 2N+1 bit word is dropped
                    acc_d   = sum[N:1];
                    mq_d    = {sum[0], mq_q[N-1:1]};
                    count_d = count_q - CW'(1);
                    if (count_q == '0) begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        product_d = {sum, mq_q[N-1:1]};
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_add_mul_seq.sv
// Self-checking bench for add_mul_seq at N=32 and N=8 against a*b.
module tb_add_mul_seq;

    logic        clk;
    logic        rst_n;

    logic        start32, flush32, busy32, done32;
    logic [31:0] op_a32, op_b32;
    logic [63:0] product32;

    logic        start8, flush8, busy8, done8;
    logic [7:0]  op_a8, op_b8;
    logic [15:0] product8;

    int n_cmp;
    int n_err;

    add_mul_seq #(.N(32)) dut32 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start32),
        .flush   (flush32),
        .op_a    (op_a32),
        .op_b    (op_b32),
        .busy    (busy32),
        .done    (done32),
        .product (product32)
    );

    add_mul_seq #(.N(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start8),
        .flush   (flush8),
        .op_a    (op_a8),
        .op_b    (op_b8),
        .busy    (busy8),
        .done    (done8),
        .product (product8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a 32-bit op at the next edge; returns edges until done (40 = timeout)
    task automatic do_op32(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [63:0] p);
        op_a32 = a; op_b32 = b; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        lat = 0;
        while (!done32 && lat < 40) begin
            tick();
            lat++;
        end
        p = product32;
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [15:0] p);
        op_a8 = a; op_b8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 16) begin
            tick();
            lat++;
        end
        p = product8;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start32 = 1'b0; flush32 = 1'b0; op_a32 = '0; op_b32 = '0;
        start8 = 1'b0;  flush8 = 1'b0;  op_a8 = '0;  op_b8 = '0;
        #23;
        n_cmp += 6;
        if (busy32 !== 1'b0) begin n_err++; $display("FAIL reset_busy32: got %b expected 0", busy32); end
        if (done32 !== 1'b0) begin n_err++; $display("FAIL reset_done32: got %b expected 0", done32); end
        if (product32 !== 64'h0) begin n_err++; $display("FAIL reset_product32: got %h expected 0", product32); end
        if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset_busy8: got %b expected 0", busy8); end
        if (done8 !== 1'b0) begin n_err++; $display("FAIL reset_done8: got %b expected 0", done8); end
        if (product8 !== 16'h0) begin n_err++; $display("FAIL reset_product8: got %h expected 0", product8); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        op_a32 = 32'd3; op_b32 = 32'd5; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        for (int e = 0; e < 32; e++) begin
            n_cmp++;
            if (busy32 !== 1'b1 || done32 !== 1'b0) begin
                n_err++;
                $display("FAIL basic_busy edge %0d: got busy=%b done=%b expected busy=1 done=0", e, busy32, done32);
            end
            tick();
        end
        n_cmp += 3;
        if (done32 !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b expected 1", done32); end
        if (busy32 !== 1'b0) begin n_err++; $display("FAIL basic_busy_end: got %b expected 0", busy32); end
        if (product32 !== 64'h0000_0000_0000_000F) begin
            n_err++; $display("FAIL basic_product: got %h expected 000000000000000f", product32);
        end
        tick();
        n_cmp++;
        if (done32 !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b expected 0", done32); end
    endtask

    task automatic test_max();
        int lat; logic [63:0] p;
        do_op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, p);
        n_cmp += 2;
        if (lat !== 32) begin n_err++; $display("FAIL max_latency: got %0d expected 32", lat); end
        if (p !== 64'hFFFF_FFFE_0000_0001) begin n_err++; $display("FAIL max_product: got %h expected fffffffe00000001", p); end
        tick();
    endtask

    task automatic test_zero();
        int lat; logic [63:0] p;
        do_op32(32'h0, 32'h1234, lat, p);
        n_cmp += 2;
        if (lat !== 32) begin n_err++; $display("FAIL zero_latency: got %0d expected 32", lat); end
        if (p !== 64'h0) begin n_err++; $display("FAIL zero_product: got %h expected 0", p); end
        do_op32(32'h89AB_CDEF, 32'h0, lat, p);
        n_cmp += 2;
        if (lat !== 32) begin n_err++; $display("FAIL zero_b_latency: got %0d expected 32", lat); end
        if (p !== 64'h0) begin n_err++; $display("FAIL zero_b_product: got %h expected 0", p); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] a1, b1, a2, b2;
        logic [63:0] exp1, exp2;
        a1 = 32'h1357_9BDF; b1 = 32'h0246_8ACE;
        a2 = 32'hDEAD_BEEF; b2 = 32'h0000_CAFE;
        exp1 = 64'(a1) * 64'(b1);
        exp2 = 64'(a2) * 64'(b2);
        op_a32 = a1; op_b32 = b1; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        lat = 0;
        for (int e = 1; e < 5; e++) begin tick(); lat++; end
        // Retry with different operands at edge 5 must be ignored
        op_a32 = 32'hFFFF_FFFF; op_b32 = 32'hFFFF_FFFF; start32 = 1'b1;
        tick(); lat++;
        start32 = 1'b0;
        while (!done32 && lat < 40) begin tick(); lat++; end
        n_cmp += 2;
        if (lat !== 32) begin n_err++; $display("FAIL b2b_first_latency: got %0d expected 32", lat); end
        if (product32 !== exp1) begin n_err++; $display("FAIL b2b_first_product: got %h expected %h", product32, exp1); end
        // Start again in the done cycle
        op_a32 = a2; op_b32 = b2; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        n_cmp += 2;
        if (done32 !== 1'b0) begin n_err++; $display("FAIL b2b_done_clear: got %b expected 0", done32); end
        if (busy32 !== 1'b1) begin n_err++; $display("FAIL b2b_second_accept: got busy=%b expected 1", busy32); end
        lat = 0;
        while (!done32 && lat < 40) begin tick(); lat++; end
        n_cmp += 2;
        if (lat !== 32) begin n_err++; $display("FAIL b2b_second_latency: got %0d expected 32", lat); end
        if (product32 !== exp2) begin n_err++; $display("FAIL b2b_second_product: got %h expected %h", product32, exp2); end
        tick();
    endtask

    task automatic test_flush();
        int lat; int seen_done;
        logic [63:0] prior;
        do_op32(32'd1000, 32'd777, lat, prior);
        tick();
        for (int pass = 0; pass < 2; pass++) begin
            op_a32 = 32'h7777_1111; op_b32 = 32'h3333_2222; start32 = 1'b1;
            tick();
            start32 = 1'b0;
            for (int e = 1; e < 10; e++) tick();
            flush32 = 1'b1;
            start32 = (pass == 1);
            tick();
            flush32 = 1'b0; start32 = 1'b0;
            n_cmp += 2;
            if (busy32 !== 1'b0) begin n_err++; $display("FAIL flush_busy pass %0d: got %b expected 0", pass, busy32); end
            if (product32 !== prior) begin n_err++; $display("FAIL flush_product pass %0d: got %h expected %h", pass, product32, prior); end
            seen_done = 0;
            for (int e = 0; e < 40; e++) begin
                if (done32 === 1'b1) seen_done++;
                tick();
            end
            n_cmp++;
            if (seen_done !== 0) begin n_err++; $display("FAIL flush_no_done pass %0d: got %0d pulses expected 0", pass, seen_done); end
        end
        // Flush and start together while idle: no accept
        flush32 = 1'b1; start32 = 1'b1;
        tick();
        flush32 = 1'b0; start32 = 1'b0;
        n_cmp += 2;
        if (busy32 !== 1'b0) begin n_err++; $display("FAIL flush_idle_start: got busy=%b expected 0", busy32); end
        if (product32 !== prior) begin n_err++; $display("FAIL flush_idle_product: got %h expected %h", product32, prior); end
    endtask

    task automatic test_reset_midop();
        op_a32 = 32'h0BAD_F00D; op_b32 = 32'h1234_5678; start32 = 1'b1;
        op_a8 = 8'hA5; op_b8 = 8'h3C; start8 = 1'b1;
        tick();
        start32 = 1'b0; start8 = 1'b0;
        for (int e = 1; e < 17; e++) tick();
        // Async assertion between edges
        rst_n = 1'b0;
        #1;
        n_cmp += 4;
        if (busy32 !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy32: got %b expected 0", busy32); end
        if (done32 !== 1'b0) begin n_err++; $display("FAIL rst_mid_done32: got %b expected 0", done32); end
        if (product32 !== 64'h0) begin n_err++; $display("FAIL rst_mid_product32: got %h expected 0", product32); end
        if (product8 !== 16'h0) begin n_err++; $display("FAIL rst_mid_product8: got %h expected 0", product8); end
        #2;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (done32 !== 1'b0 || busy32 !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_after: got busy=%b done=%b expected 0 0", busy32, done32);
        end
    endtask

    task automatic test_random32();
        int lat; logic [63:0] p, e;
        logic [31:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom; b = $urandom;
            if (i % 10 == 0) a = a & 32'h0000_00FF;
            if (i % 13 == 0) b = '1;
            e = 64'(a) * 64'(b);
            do_op32(a, b, lat, p);
            n_cmp += 2;
            if (lat !== 32) begin n_err++; $display("FAIL rand32_latency op %0d: got %0d expected 32", i, lat); end
            if (p !== e) begin n_err++; $display("FAIL rand32_product op %0d: %h*%h got %h expected %h", i, a, b, p, e); end
        end
        tick();
    endtask

    task automatic test_random8();
        int lat; logic [15:0] p, e;
        logic [7:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            e = 16'(a) * 16'(b);
            do_op8(a, b, lat, p);
            n_cmp += 2;
            if (lat !== 8) begin n_err++; $display("FAIL rand8_latency op %0d: got %0d expected 8", i, lat); end
            if (p !== e) begin n_err++; $display("FAIL rand8_product op %0d: %h*%h got %h expected %h", i, a, b, p, e); end
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_back_to_back();
        test_flush();
        test_reset_midop();
        test_random32();
        test_random8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
